// File: rtl/alu_muldiv_seq.sv
// Sequential 8-bit multiply / unsigned divide engine that borrows an external
// shared ALU. Multiply is shift-and-add (low byte kept), divide is restoring
// division, both taking exactly 8 RUN iterations. A divide by zero bypasses
// RUN and reports err with result = 8'hFF and remainder = dividend.
module alu_muldiv_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       op_div,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [7:0] alu_out,
  input  logic       alu_less,
  output logic [7:0] alu_in1,
  output logic [7:0] alu_in2,
  output logic [4:0] alu_op,
  output logic       busy,
  output logic       done,
  output logic [7:0] result,
  output logic [7:0] remainder,
  output logic       err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [4:0] OP_AND = 5'b00000;
  localparam logic [4:0] OP_ADD = 5'b00100;
  localparam logic [4:0] OP_SUB = 5'b00101;

  logic [1:0] state;
  logic [2:0] cnt;
  logic       op_reg;
  logic [7:0] acc;
  logic [7:0] mcand;
  logic [7:0] mplier;
  logic [7:0] rem;
  logic [7:0] q;
  logic [7:0] dvsr;

  logic [8:0] s;
  logic [7:0] acc_nxt;
  logic       div_take;
  logic [7:0] rem_nxt;
  logic [7:0] q_nxt;
  logic       accept;

  assign busy   = (state == S_RUN);
  assign done   = (state == S_DONE);
  // A new request is only taken when no iteration is in flight.
  assign accept = start && (state != S_RUN);

  // Drive the shared ALU and form the next-iteration values from its answer.
  always_comb begin
    s       = {rem, q[7]};
    alu_in1 = 8'd0;
    alu_in2 = 8'd0;
    alu_op  = OP_AND;
    if (state == S_RUN) begin
      if (op_reg) begin
        alu_in1 = s[7:0];
        alu_in2 = dvsr;
        alu_op  = OP_SUB;
      end else begin
        alu_in1 = acc;
        alu_in2 = mcand;
        alu_op  = OP_ADD;
      end
    end
    acc_nxt  = mplier[0] ? alu_out : acc;
    // s[8] set means the shifted remainder already exceeds any 8-bit divisor;
    // the 8-bit difference is still exact because s - divisor < 256.
    div_take = s[8] | ~alu_less;
    rem_nxt  = div_take ? alu_out : s[7:0];
    q_nxt    = {q[6:0], div_take};
  end

  // Control FSM, iteration registers and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= 3'd0;
      op_reg    <= 1'b0;
      acc       <= 8'd0;
      mcand     <= 8'd0;
      mplier    <= 8'd0;
      rem       <= 8'd0;
      q         <= 8'd0;
      dvsr      <= 8'd0;
      result    <= 8'd0;
      remainder <= 8'd0;
      err       <= 1'b0;
    end else begin
      case (state)
        S_RUN: begin
          if (op_reg) begin
            rem <= rem_nxt;
            q   <= q_nxt;
          end else begin
            acc    <= acc_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
          end
          if (cnt == 3'd7) begin
            // Last iteration: publish the value being written this cycle.
            state     <= S_DONE;
            result    <= op_reg ? q_nxt : acc_nxt;
            remainder <= op_reg ? rem_nxt : 8'd0;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        S_IDLE, S_DONE: begin
          state <= S_IDLE;
          if (accept) begin
            op_reg <= op_div;
            acc    <= 8'd0;
            mcand  <= a;
            mplier <= b;
            rem    <= 8'd0;
            q      <= a;
            dvsr   <= b;
            cnt    <= 3'd0;
            err    <= 1'b0;
            if (op_div && (b == 8'd0)) begin
              state     <= S_DONE;
              err       <= 1'b1;
              result    <= 8'hFF;
              remainder <= a;
            end else begin
              state <= S_RUN;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_muldiv_seq.md
ALU_MULDIV_SEQ -- requirements
Module: alu_muldiv_seq

Interface
REQ-001: The block SHALL use one clock and an asynchronous, active-low reset; all state SHALL be cleared on reset.
REQ-002: Ports SHALL be as follows (clock and reset first):
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request pulse, sampled on rising clk
- op_div  in  1  0 = multiply, 1 = unsigned divide; sampled with start
- a  in  8  multiplicand or dividend; sampled with start
- b  in  8  multiplier or divisor; sampled with start
- alu_out  in  8  result from the shared 8-bit ALU
- alu_less  in  1  ALU flag: alu_in1 < alu_in2, unsigned
- alu_in1  out  8  ALU operand 1
- alu_in2  out  8  ALU operand 2
- alu_op  out  5  ALU opcode: 00100 = ADD, 00101 = SUB, 00000 = AND
- busy  out  1  operation in progress
- done  out  1  one-cycle completion pulse
- result  out  8  low product byte (mul) or quotient (div)
- remainder  out  8  division remainder; 0 after a multiply
- err  out  1  divide-by-zero flag for the last operation

Function
REQ-003: The FSM SHALL have three states: IDLE, RUN and DONE.
- IDLE -> RUN on start with no divide-by-zero.
- RUN -> DONE after exactly 8 iterations.
- DONE -> IDLE after one cycle.
REQ-004: start SHALL be accepted only in IDLE or DONE, and SHALL be ignored while busy=1.
REQ-005: On acceptance, the block SHALL latch op_div, a and b, clear err, and load the iteration counter with 0.
REQ-006: busy SHALL be 1 for exactly the 8 RUN cycles that follow acceptance.
REQ-007: done SHALL be 1 for exactly the one cycle after the last RUN cycle.
REQ-008: result, remainder and err SHALL become valid in the done cycle and hold until the next accepted start.
REQ-009: Multiply SHALL use these initial values: acc = 0, mcand = a, mplier = b.
REQ-010: Each multiply RUN cycle SHALL do the following:
- drive alu_in1 = acc, alu_in2 = mcand, alu_op = ADD;
- if mplier[0] = 1, set acc <= alu_out;
- set mcand <= mcand << 1 and mplier <= mplier >> 1, as internal register shifts.
REQ-011: After a multiply, result SHALL equal (a*b) mod 256 and remainder SHALL be 0.
REQ-012: Divide SHALL use these initial values: rem = 0, q = a.
REQ-013: Each divide RUN cycle SHALL do the following:
- form the 9-bit value s = {rem, q[7]};
- drive alu_in1 = s[7:0], alu_in2 = b, alu_op = SUB.
REQ-014: In a divide RUN cycle, if s[8] = 1 or alu_less = 0, the block SHALL set rem <= alu_out and q <= {q[6:0], 1}.
REQ-015: Otherwise, the block SHALL set rem <= s[7:0] and q <= {q[6:0], 0}.
REQ-016: After a divide, result SHALL equal floor(a/b) and remainder SHALL equal a mod b, both unsigned.
REQ-017: A divide with b = 0 SHALL skip RUN and go directly to DONE on the next cycle.
REQ-018: In that divide-by-zero case, busy SHALL stay 0, and the done cycle SHALL present err = 1, result = 8'hFF and remainder = a.
REQ-019: In IDLE and DONE, the block SHALL drive alu_in1 = 0, alu_in2 = 0 and alu_op = AND.
REQ-020: The ALU outputs SHALL be used combinationally in the same cycle; the block SHALL add no ALU pipeline stage.
REQ-021: A start in the DONE cycle SHALL be accepted, giving back-to-back operations with no idle gap.
REQ-022: The iteration counter SHALL be 3 bits wide and SHALL NOT wrap into a ninth iteration.

Reset
REQ-023: While rst_n = 0, the block SHALL be in IDLE with busy, done, err, result and remainder all 0 and the internal registers cleared.
REQ-024: A reset asserted mid-operation SHALL abort the operation immediately; no done pulse SHALL follow.
REQ-025: After rst_n is released, the first rising clk edge SHALL be able to accept start.

Verification
REQ-026: The bench SHALL cover these directed scenarios:
- mul a=13, b=11 -> busy for 8 cycles, then done with result=0x8F, remainder=0, err=0.
- mul a=20, b=20 -> result=0x90 (400 mod 256); also mul a=0xFF, b=0xFF -> result=0x01.
- div a=200, b=7 -> result=28, remainder=4; also div a=255, b=255 -> result=1, remainder=0; also div a=5, b=200 -> result=0, remainder=5.
- div a=37, b=0 -> done on the cycle after start, busy never 1, err=1, result=0xFF, remainder=0x25.
- start pulsed during RUN with different operands -> ignored; the first result is unchanged and exactly one done pulse occurs.
- rst_n dropped at RUN cycle 4 -> outputs 0 immediately and no done; a new mul 3*5 after release -> result=15.
REQ-027: The bench SHALL run a random sweep of 1000 operations that checks each result against a reference model.
REQ-028: The random sweep SHALL include back-to-back starts issued in the DONE cycle.
